// File: rtl/pwm_decoder_pkg.sv
// pwm_decoder_pkg: shared types and constants for the PWM decoder.
// FSM states plus averaging depth/shift for the PWM_DECODER_AVG_EN build.
package pwm_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam int AVG_DEPTH = 4;
  localparam int AVG_SHIFT = 2;

endpackage

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge: multi-flop synchronizer for the async PWM pin.
// Edge detect compares against a level that only updates on en ticks.
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic signal,
  output logic s_sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev;

  // Shift chain runs every clk to settle metastability
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal};
    end
  end

  // Previous level as seen on the last en tick
  always_ff @(posedge clk) begin
    if (!reset) begin
      s_prev <= 1'b0;
    end else if (en) begin
      s_prev <= s_sync;
    end
  end

  assign s_sync = sync_q[SYNC_STAGES-1];
  assign rise   = en & s_sync & ~s_prev;
  assign fall   = en & ~s_sync & s_prev;

endmodule

// File: rtl/pwm_decoder.sv
// pwm_decoder: measures high time and period of an async PWM input in en ticks.
// Define PWM_DECODER_AVG_EN to report the mean of every four periods.
module pwm_decoder
  import pwm_decoder_pkg::*;
#(
  parameter int CW          = 13,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 8191
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          signal,
  output logic [CW-1:0] high_cnt,
  output logic [CW-1:0] period_cnt,
  output logic          valid,
  output logic          timeout,
  output logic          stuck_level
);

  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  state_t        state;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] pcnt;
  logic          s_sync;
  logic          rise;
  logic          fall;
  logic          done;
  logic          tmo_hit;

  pwm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .signal(signal),
    .s_sync(s_sync),
    .rise  (rise),
    .fall  (fall)
  );

  // A rise in LOW closes the period and takes priority over loss of signal
  assign done    = en & (state == LOW) & rise;
  assign tmo_hit = en & (pcnt >= TMO) &
                   ((state == HIGH) | ((state == LOW) & ~rise));

  // Measurement FSM; advances only on en ticks
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      hcnt        <= '0;
      pcnt        <= '0;
      timeout     <= 1'b0;
      stuck_level <= 1'b0;
    end else if (tmo_hit) begin
      state       <= IDLE;
      timeout     <= 1'b1;
      stuck_level <= s_sync;
    end else if (en) begin
      unique case (state)
        IDLE: begin
          if (rise) begin
            state   <= HIGH;
            hcnt    <= CW'(1);
            pcnt    <= CW'(1);
            timeout <= 1'b0;
          end
        end
        HIGH: begin
          pcnt <= pcnt + CW'(1);
          if (fall) state <= LOW;
          else      hcnt  <= hcnt + CW'(1);
        end
        LOW: begin
          if (rise) begin
            state <= HIGH;
            hcnt  <= CW'(1);
            pcnt  <= CW'(1);
          end else begin
            pcnt  <= pcnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PWM_DECODER_AVG_EN
  logic [CW+1:0] sum_h;
  logic [CW+1:0] sum_p;
  logic [CW+1:0] nxt_h;
  logic [CW+1:0] nxt_p;
  logic [1:0]    idx;

  assign nxt_h = sum_h + {2'b00, hcnt};
  assign nxt_p = sum_p + {2'b00, pcnt};

  // Accumulate finished periods; publish the mean on every fourth
  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_h      <= '0;
      sum_p      <= '0;
      idx        <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      valid      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (tmo_hit) begin
        sum_h <= '0;
        sum_p <= '0;
        idx   <= '0;
      end else if (done) begin
        if (idx == 2'(AVG_DEPTH - 1)) begin
          high_cnt   <= CW'(nxt_h >> AVG_SHIFT);
          period_cnt <= CW'(nxt_p >> AVG_SHIFT);
          valid      <= 1'b1;
          sum_h      <= '0;
          sum_p      <= '0;
          idx        <= '0;
        end else begin
          sum_h <= nxt_h;
          sum_p <= nxt_p;
          idx   <= idx + 2'd1;
        end
      end
    end
  end
`else
  // Publish each finished period directly
  always_ff @(posedge clk) begin
    if (!reset) begin
      high_cnt   <= '0;
      period_cnt <= '0;
      valid      <= 1'b0;
    end else begin
      valid <= done;
      if (done) begin
        high_cnt   <= hcnt;
        period_cnt <= pcnt;
      end
    end
  end
`endif

endmodule

// File: doc/pwm_decoder.md
Name: pwm_decoder

Overview:
Receive-side counterpart of the PWM generator in the photonic-switch top. Takes the asynchronous PWM `signal` pin and synchronizes it into the core domain. Measures high time and period in units of `en` ticks, then reports each completed period as a (high_cnt, period_cnt) pair with a one-cycle valid strobe. Used for closed-loop checking of the set/reset PWM path and for reading back external PWM sources.

Parameters:
CW, 13, width of high/period counters (matches the 13-bit W word)
SYNC_STAGES, 2, flip-flop stages in the input synchronizer (min 2)
TIMEOUT, 8191, en ticks without a valid edge before declaring loss of signal (must be ≤ 2^CW-1)

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-low reset
en  input  1  sample-qualifying tick (e.g. en_8MHz); all counting and edge detection happen only on en=1 cycles
signal  input  1  asynchronous PWM input
high_cnt  output  CW  high ticks of last completed period
period_cnt  output  CW  total ticks of last completed period
valid  output  1  one-clk pulse when high_cnt/period_cnt update
timeout  output  1  sticky loss-of-signal flag
stuck_level  output  1  sampled level at the moment timeout asserted

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE; high_cnt=0, period_cnt=0, valid=0, timeout=0, stuck_level=0; synchronizer and edge register cleared to 0. Reset overrides all other inputs.
- Synchronizer shifts every clk. Edge register s_prev updates only on en=1. Rising edge is defined as s_sync=1 and s_prev=0 on an en=1 cycle.
- Latency: an input rising edge is detected at the first en=1 cycle that is at least SYNC_STAGES clk cycles later. valid is registered and rises one clk after detection.
- FSM, evaluated only on en=1; state and counters hold when en=0:
  - IDLE: wait for rising edge, then go to HIGH with hcnt=1, pcnt=1; timeout cleared. No valid is issued on the first edge.
  - HIGH: pcnt++. If s_sync=1 then hcnt++; else go to LOW.
  - LOW: on rising edge, latch high_cnt=hcnt and period_cnt=pcnt, pulse valid, set hcnt=1, pcnt=1, go to HIGH. Otherwise pcnt++.
- Period counts the rising-edge tick and excludes the next rising-edge tick. Example: 25 high + 75 low ticks gives period_cnt=100, high_cnt=25.
- Timeout: in HIGH or LOW, if pcnt would exceed TIMEOUT, go to IDLE, set timeout=1 and stuck_level=s_sync. high_cnt/period_cnt keep their last values and valid is not pulsed. timeout clears on the next rising edge.
- Counters never wrap, since TIMEOUT ≤ 2^CW-1 bounds pcnt.
- Glitch shorter than one en period: not guaranteed to be seen. A glitch that is seen counts as a full edge (no filtering).
- Reset mid-period: partial counts are discarded and the next rising edge is treated as the first.

Optional Feature:
PWM_DECODER_AVG_EN
- Defined: accumulates 4 consecutive measurements in CW+2-bit sums. valid pulses every 4th period with high_cnt/period_cnt = sum>>2 (truncated). Timeout or reset clears the accumulators and the 2-bit sample index.
- Undefined: valid on every completed period as above. No accumulator logic.

Decomposition:
- Package pwm_decoder_pkg: FSM state enum (IDLE, HIGH, LOW), AVG_DEPTH=4, AVG_SHIFT=2.
- One sub-module, pwm_sync_edge: SYNC_STAGES synchronizer plus en-qualified rising/falling edge detect. Outputs s_sync, rise, fall.

Test Plan:
- en=1 every clk; PWM 25 clk high / 75 low, 3 periods -> valid 2 times, each high_cnt=25, period_cnt=100; no valid on the first edge.
- en=1 every 4th clk; PWM 40 clk high / 160 low -> high_cnt=10, period_cnt=50.
- TIMEOUT=50; signal held low after 2 good periods -> timeout=1 and stuck_level=0 at tick 51 after the last rising edge, last counts retained; next edge clears timeout; valid again after the following edge.
- Signal held high with TIMEOUT=50 -> timeout=1, stuck_level=1; valid never asserts.
- reset=0 for 1 clk mid-LOW -> all outputs 0 next clk; first post-reset edge gives no valid; the second gives correct counts.
- PWM_DECODER_AVG_EN, period 100, high sequence 20,24,28,32 -> a single valid after the 4th period with high_cnt=26, period_cnt=100.
